alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 32-bit ripple ALU.
- Adds a valid/ready handshake on both input and output, a one-entry output buffer and an iterative shift-add multiplier.
- Sits between decode/operand fetch and writeback in the multi-cycle datapath.
- Single-cycle ops complete one cycle after accept; MUL takes WIDTH cycles.

Parameters:
WIDTH, 32, operand/result width in bits (minimum 2).

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  block accepts operation this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
control  input  3  opcode: 000 MUL, 001 SLT, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 NOR, 111 XOR
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
out  output  WIDTH  result
overflow  output  1  overflow flag
zero  output  1  out == 0
negative  output  1  out[WIDTH-1]
busy  output  1  multiply in progress

Behaviour:
- Reset (async, active-high): state IDLE; out_valid=0, out=0, overflow=0, zero=0, negative=0, busy=0; iteration counter=0. Reset mid-multiply aborts it; no partial result is ever presented.
- Accept: fires when in_valid && in_ready on a rising edge. Operands and opcode are captured at that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational on out_ready, so a result can drain and a new op be accepted in the same cycle.
- Output hold: while out_valid && !out_ready, out/flags/out_valid hold stable. out_valid drops the edge after out_ready, unless a new result loads that edge.
- States:
  - IDLE: accept of a non-MUL op loads the output register at that edge; out_valid=1 next cycle (latency 1). Accept of MUL goes to MUL with acc=0, mcand=A, mplier=B, cnt=0, busy=1.
  - MUL: each cycle, if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; cnt++. After WIDTH iterations, load out=acc[WIDTH-1:0] and go to DONE.
  - DONE: out_valid=1, busy=0. Return to IDLE on the same edge the result is loaded, so a MUL accepted at edge T shows out_valid after edge T+WIDTH+1.
  - in_ready=0 throughout MUL.
- Arithmetic (all modulo 2^WIDTH):
  - ADD: out = A+B; overflow = signed overflow (carry into MSB XOR carry out of MSB).
  - SUB: out = A + ~B + 1; overflow likewise.
  - SLT: out = 1 if signed A < B, else 0. Must be correct even when A−B overflows. overflow=0.
  - AND/OR/NOR/XOR: bitwise; overflow=0.
  - MUL: unsigned; overflow=1 iff the full 2·WIDTH product's upper WIDTH bits are nonzero. The accumulator is 2·WIDTH bits wide.
- Flags: zero = ~|out; negative = out[WIDTH-1]. Both are registered with out and are valid only with out_valid.
- in_valid with in_ready=0: no capture, no side effects. The producer holds its inputs.
- Back-to-back single-cycle ops with out_ready tied high: one result per cycle.

Test Plan:
- Reset mid-MUL: WIDTH=32, accept MUL A=7 B=9, assert reset 5 cycles later → all outputs 0 immediately; after release in_ready=1, busy=0, no out_valid.
- ADD overflow: WIDTH=32, ADD 0x7FFFFFFF+1 → next cycle out=0x80000000, overflow=1, negative=1, zero=0. Then SUB 5−5 → out=0, zero=1, overflow=0.
- SLT signed overflow case: SLT A=0x80000000 B=0x00000001 → out=1; SLT A=0x7FFFFFFF B=0xFFFFFFFF → out=0; overflow=0 in both.
- MUL latency and overflow: accept MUL 0x0000FFFF×0x00010001 at edge T → out=0xFFFFFFFF, overflow=0 after edge T+33, busy high for 32 cycles, in_ready low meanwhile. Then MUL 0x10000×0x10000 → out=0, overflow=1, zero=1.
- Backpressure: out_ready=0, accept AND 0xF0F0F0F0&0xFF00FF00 → out=0xF000F000 held, in_ready=0. Raise out_ready with in_valid XOR pending → both handshakes fire the same edge; the XOR result appears next cycle.
- Parametric: WIDTH=8, ADD 0x7F+0x01 → 0x80, overflow=1; MUL 0x10×0x10 → 0x00, overflow=1, out_valid after 9 edges.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides, a one-entry result
// buffer and an iterative shift-add multiplier (MUL takes WIDTH iterations).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 valid_q, valid_d;

    logic                 accept_s;
    logic                 load_s;
    logic [WIDTH-1:0]     res_s;
    logic                 res_ovf_s;
    logic [WIDTH:0]       alu_s;

    // Single-cycle ops: returns {overflow, result}. SLT uses a true signed
    // compare so it stays correct when A-B would overflow.
    function automatic logic [WIDTH:0] alu_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] bx;
        logic             v;
        r  = {WIDTH{1'b0}};
        bx = ~b;
        v  = 1'b0;
        case (op)
            3'b001: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b010: begin
                r = a + b;
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b011: begin
                r = a + bx + {{(WIDTH-1){1'b0}}, 1'b1};
                v = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = ~(a | b);
            3'b111: r = a ^ b;
            default: r = {WIDTH{1'b0}};
        endcase
        return {v, r};
    endfunction

    assign alu_s     = alu_op(control, A, B);
    assign in_ready  = (state_q == S_IDLE) && (!valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out       = out_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign busy      = (state_q == S_MUL);

    // Next-state: FSM sequencing, multiplier iteration and output-buffer load/drain.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        load_s    = 1'b0;
        res_s     = {WIDTH{1'b0}};
        res_ovf_s = 1'b0;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s && (control == 3'b000)) begin
                    state_d  = S_MUL;
                    acc_d    = {(2*WIDTH){1'b0}};
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    cnt_d    = {CW{1'b0}};
                end else if (accept_s) begin
                    load_s    = 1'b1;
                    res_s     = alu_s[WIDTH-1:0];
                    res_ovf_s = alu_s[WIDTH];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                load_s    = 1'b1;
                res_s     = acc_q[WIDTH-1:0];
                res_ovf_s = |acc_q[2*WIDTH-1:WIDTH];
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_s) begin
            out_d   = res_s;
            ovf_d   = res_ovf_s;
            zero_d  = ~|res_s;
            neg_d   = res_s[WIDTH-1];
            valid_d = 1'b1;
        end else begin
            out_d = out_q;
        end
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            out_q    <= {WIDTH{1'b0}};
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model plus a per-cycle
// scoreboard for WIDTH=32, and a directed/random section for WIDTH=8.
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, out;
    logic [2:0]  control;
    logic        overflow, zero, negative, busy;

    logic       in_valid_8, in_ready_8, out_valid_8, out_ready_8;
    logic [7:0] a_8, b_8, out_8;
    logic [2:0] control_8;
    logic       overflow_8, zero_8, negative_8, busy_8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd_ready = 1'b0;

    typedef struct {
        logic [31:0] r;
        logic        v;
        int          due;
        bit          mul;
    } item_t;
    item_t q[$];

    alu_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .control(control), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .overflow(overflow), .zero(zero), .negative(negative), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .A(a_8), .B(b_8), .control(control_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out(out_8), .overflow(overflow_8), .zero(zero_8), .negative(negative_8), .busy(busy_8)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic on w-bit operands, done with wide signed/unsigned integers.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int w, output logic [31:0] r, output logic v);
        longint unsigned mask, ua, ub, p;
        longint          sa, sb, full, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ((ua >> (w - 1)) != 0) ? $signed(ua) - (64'sd1 <<< w) : $signed(ua);
        sb   = ((ub >> (w - 1)) != 0) ? $signed(ub) - (64'sd1 <<< w) : $signed(ub);
        smax = (64'sd1 <<< (w - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (w - 1));
        v    = 1'b0;
        p    = 64'd0;
        case (op)
            3'd0: begin p = ua * ub; v = (p >> w) != 0; end
            3'd1: p = (sa < sb) ? 64'd1 : 64'd0;
            3'd2: begin full = sa + sb; p = ua + ub; v = (full > smax) || (full < smin); end
            3'd3: begin full = sa - sb; p = ua - ub; v = (full > smax) || (full < smin); end
            3'd4: p = ua & ub;
            3'd5: p = ua | ub;
            3'd6: p = ~(ua | ub);
            default: p = ua ^ ub;
        endcase
        r = 32'(p & mask);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard for the 32-bit instance: expected valid/ready/busy and result every cycle.
    initial begin
        logic [31:0] r;
        logic        v, exp_valid, mul_run, exp_busy, exp_rdy;
        forever begin
            @(negedge clock);
            if (reset) begin
                q.delete();
                chk("rst_outs", {27'd0, out_valid, busy, overflow, zero, negative, out}, 64'd0);
            end else begin
                exp_valid = (q.size() > 0) && (q[0].due <= cyc);
                mul_run   = (q.size() > 0) && q[0].mul && (q[0].due > cyc);
                exp_busy  = mul_run && (cyc < q[0].due - 1);
                exp_rdy   = !mul_run && (!exp_valid || out_ready);
                chk("out_valid", out_valid, exp_valid);
                chk("busy", busy, exp_busy);
                chk("in_ready", in_ready, exp_rdy);
                if (exp_valid) begin
                    chk("out", out, q[0].r);
                    chk("overflow", overflow, q[0].v);
                    chk("zero", zero, q[0].r == 32'd0);
                    chk("negative", negative, q[0].r[31]);
                    if (out_ready) void'(q.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    model(control, A, B, 32, r, v);
                    q.push_back('{r: r, v: v, mul: (control == 3'd0),
                                  due: cyc + 1 + ((control == 3'd0) ? 33 : 0)});
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rnd_ready) out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1; control = op; A = a; B = b;
        @(negedge clock);
        while (!in_ready && n < 200) begin n++; @(negedge clock); end
        if (n >= 200) chk("issue_timeout", 64'(n), 64'd0);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Runs one op on the WIDTH=8 instance and checks latency and result against the model.
    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        logic [31:0] r;
        logic        v;
        in_valid_8 = 1'b1; control_8 = op; a_8 = a; b_8 = b;
        @(negedge clock);
        while (!in_ready_8 && n < 50) begin n++; @(negedge clock); end
        if (n >= 50) chk("issue8_timeout", 64'(n), 64'd0);
        @(posedge clock); #1;
        in_valid_8 = 1'b0;
        n = 0;
        @(negedge clock);
        while (!out_valid_8 && n < 30) begin n++; @(negedge clock); end
        chk("w8_latency", 64'(n), (op == 3'd0) ? 64'd9 : 64'd0);
        model(op, {24'd0, a}, {24'd0, b}, 8, r, v);
        chk("w8_out", out_8, r[7:0]);
        chk("w8_ovf", overflow_8, v);
        chk("w8_zero", zero_8, r[7:0] == 8'd0);
        chk("w8_neg", negative_8, r[7]);
        tick();
    endtask

    initial begin
        logic [31:0] r;
        logic        v;
        int          c0, bc, seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = 32'd0; B = 32'd0; control = 3'd0;
        in_valid_8 = 1'b0; out_ready_8 = 1'b1; a_8 = 8'd0; b_8 = 8'd0; control_8 = 3'd0;
        #2;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_out", out, 32'd0);
        chk("reset_ready8", in_ready_8, 1'b1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        model(3'd2, 32'h7FFF_FFFF, 32'h1, 32, r, v); chk("pin_add", {v, r}, {1'b1, 32'h8000_0000});
        model(3'd1, 32'h8000_0000, 32'h1, 32, r, v); chk("pin_slt1", {v, r}, 33'd1);
        model(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32, r, v); chk("pin_slt2", {v, r}, 33'd0);
        model(3'd0, 32'h0000_FFFF, 32'h0001_0001, 32, r, v); chk("pin_mul1", {v, r}, {1'b0, 32'hFFFF_FFFF});
        model(3'd0, 32'h0001_0000, 32'h0001_0000, 32, r, v); chk("pin_mul2", {v, r}, {1'b1, 32'h0});
        model(3'd2, 32'h7F, 32'h01, 8, r, v); chk("pin_add8", {v, r}, {1'b1, 32'h80});

        issue(3'd2, 32'h7FFF_FFFF, 32'h1);
        @(negedge clock);
        chk("add_ovf", {out_valid, overflow, negative, zero, out}, {4'b1110, 32'h8000_0000});
        tick();
        issue(3'd3, 32'd5, 32'd5);
        @(negedge clock);
        chk("sub_zero", {out_valid, overflow, negative, zero, out}, {4'b1001, 32'h0});
        tick();
        issue(3'd1, 32'h8000_0000, 32'h1);
        @(negedge clock);
        chk("slt_min", {out_valid, overflow, out}, {2'b10, 32'h1});
        tick();
        issue(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clock);
        chk("slt_max", {out_valid, overflow, out}, {2'b10, 32'h0});
        tick();

        issue(3'd0, 32'h0000_FFFF, 32'h0001_0001);
        bc = 0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clock);
            if (busy) bc++;
            if (i < 33) chk("mul_in_ready_low", in_ready, 1'b0);
            if (i == 32) chk("mul_not_yet_valid", out_valid, 1'b0);
            if (i == 33) chk("mul_result", {out_valid, overflow, out}, {2'b10, 32'hFFFF_FFFF});
        end
        chk("mul_busy_cycles", 64'(bc), 64'd32);
        tick();
        issue(3'd0, 32'h0001_0000, 32'h0001_0000);
        repeat (34) @(negedge clock);
        chk("mul_ovf", {out_valid, overflow, zero, out}, {3'b111, 32'h0});
        tick();

        out_ready = 1'b0;
        tick();
        issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_hold", {out_valid, in_ready, out}, {2'b10, 32'hF000_F000});
        end
        tick();
        out_ready = 1'b1;
        c0 = cyc;
        issue(3'd7, 32'h1234_5678, 32'hFFFF_0000);
        chk("bp_same_edge", 64'(cyc - c0), 64'd1);
        @(negedge clock);
        chk("bp_xor", {out_valid, out}, {1'b1, 32'hEDCB_5678});
        tick();

        c0 = cyc;
        for (int i = 0; i < 4; i++) issue(3'd2, 32'(i), 32'h10);
        chk("b2b_rate", 64'(cyc - c0), 64'd4);
        tick();

        issue(3'd0, 32'd7, 32'd9);
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        #1 chk("rst_mid_mul", {out_valid, busy, overflow, zero, negative, out}, 37'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_release", {in_ready, busy, out_valid}, 3'b100);
        seen = 0;
        repeat (40) begin @(negedge clock); if (out_valid) seen++; end
        chk("rst_no_result", 64'(seen), 64'd0);
        tick();

        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            op = 3'($urandom % 8);
            if (op == 3'd0 && ($urandom % 3) != 0) op = 3'd3;
            repeat ($urandom % 3) tick();
            issue(op, rnd_opnd(), rnd_opnd());
        end
        rnd_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (40) @(posedge clock);
        #1;

        run8(3'd2, 8'h7F, 8'h01);
        run8(3'd0, 8'h10, 8'h10);
        for (int i = 0; i < 30; i++) begin
            run8(3'($urandom % 8), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
